// File: rtl/calc_core_if.sv
// Start/done request bundle for calc_core.
// Master issues operations, slave computes.
interface calc_core_if #(
  parameter int WIDTH = 3
) ();
  logic               start;
  logic [1:0]         op;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] result;
  logic               neg;
  logic               err;

  modport master (
    output start, op, a, b,
    input  busy, done, result, neg, err
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, neg, err
  );
endinterface

// File: rtl/calc_core.sv
// Sequential add/sub/mul/div unit with start/done handshake.
// Mul is shift-add, div is restoring; both share one accumulator.
module calc_core #(
  parameter int WIDTH = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  calc_core_if.slave bus
);

  localparam int W  = WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ITER = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;

  logic [1:0]     st;
  logic [CW-1:0]  cnt;
  logic [1:0]     op_r;
  logic [2*W-1:0] acc;
  logic [W-1:0]   opnd;
  logic           neg_p;
  logic           err_p;

  logic           busy_r;
  logic           done_r;
  logic [2*W-1:0] res_r;
  logic           neg_r;
  logic           err_r;

  logic [W:0]     msum;
  logic [W:0]     rem_sh;
  logic [W:0]     diff;
  logic [2*W-1:0] acc_mul;
  logic [2*W-1:0] acc_div;
  logic [2*W-1:0] acc_acc;
  logic           neg_acc;
  logic           err_acc;
  logic           to_iter;

  // Mul: acc = {partial, multiplier}; div: acc = {remainder, quotient}.
  always_comb begin
    msum    = {1'b0, acc[2*W-1:W]} + {1'b0, opnd};
    acc_mul = acc[0] ? {msum, acc[W-1:1]}
                     : {1'b0, acc[2*W-1:1]};
    rem_sh  = {acc[2*W-1:W], acc[W-1]};
    diff    = rem_sh - {1'b0, opnd};
    acc_div = diff[W] ? {rem_sh[W-1:0], acc[W-2:0], 1'b0}
                      : {diff[W-1:0], acc[W-2:0], 1'b1};
  end

  always_comb begin
    acc_acc = '0;
    neg_acc = 1'b0;
    err_acc = 1'b0;
    to_iter = 1'b0;
    unique case (1'b1)
      bus.op == OP_ADD: begin
        acc_acc = {{W{1'b0}}, bus.a} + {{W{1'b0}}, bus.b};
      end
      bus.op == OP_SUB: begin
        neg_acc = bus.a < bus.b;
        acc_acc = neg_acc
          ? {{W{1'b0}}, bus.b - bus.a}
          : {{W{1'b0}}, bus.a - bus.b};
      end
      bus.op == OP_MUL: begin
        acc_acc = {{W{1'b0}}, bus.b};
        to_iter = 1'b1;
      end
      default: begin
        if (bus.b == '0) begin
          acc_acc = '1;
          err_acc = 1'b1;
        end else begin
          acc_acc = {{W{1'b0}}, bus.a};
          to_iter = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st     <= S_IDLE;
      cnt    <= '0;
      op_r   <= '0;
      acc    <= '0;
      opnd   <= '0;
      neg_p  <= 1'b0;
      err_p  <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      res_r  <= '0;
      neg_r  <= 1'b0;
      err_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      unique case (st)
        S_IDLE: begin
          if (bus.start) begin
            busy_r <= 1'b1;
            neg_r  <= 1'b0;
            err_r  <= 1'b0;
            op_r   <= bus.op;
            acc    <= acc_acc;
            neg_p  <= neg_acc;
            err_p  <= err_acc;
            opnd   <= (bus.op == OP_MUL) ? bus.a : bus.b;
            cnt    <= '0;
            st     <= to_iter ? S_ITER : S_DONE;
          end
        end
        S_ITER: begin
          acc <= (op_r == OP_MUL) ? acc_mul : acc_div;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(W - 1)) st <= S_DONE;
        end
        S_DONE: begin
          res_r  <= acc;
          neg_r  <= neg_p;
          err_r  <= err_p;
          done_r <= 1'b1;
          busy_r <= 1'b0;
          st     <= S_IDLE;
        end
        default: st <= S_IDLE;
      endcase
    end
  end

  assign bus.busy   = busy_r;
  assign bus.done   = done_r;
  assign bus.result = res_r;
  assign bus.neg    = neg_r;
  assign bus.err    = err_r;

endmodule

// File: tb/tb_calc_core.sv
// Randomized and directed checks of calc_core at WIDTH 3 and 8
// against an arithmetic reference model.
module tb_calc_core;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  calc_core_if #(.WIDTH(3)) if3 ();
  calc_core_if #(.WIDTH(8)) if8 ();

  calc_core #(.WIDTH(3)) u3 (
    .clk(clk), .rst_n(rst_n), .bus(if3.slave)
  );
  calc_core #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .bus(if8.slave)
  );

  task automatic check(
    input string tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive(
    input int w, input logic s, input logic [1:0] o,
    input int x, input int y
  );
    if (w == 3) begin
      if3.start = s; if3.op = o;
      if3.a = 3'(x); if3.b = 3'(y);
    end else begin
      if8.start = s; if8.op = o;
      if8.a = 8'(x); if8.b = 8'(y);
    end
  endtask

  task automatic sample(
    input int w, output logic [31:0] res,
    output logic bsy, output logic dn,
    output logic ng, output logic er
  );
    if (w == 3) begin
      res = 32'(if3.result); bsy = if3.busy;
      dn = if3.done; ng = if3.neg; er = if3.err;
    end else begin
      res = 32'(if8.result); bsy = if8.busy;
      dn = if8.done; ng = if8.neg; er = if8.err;
    end
  endtask

  task automatic chk_zero(input int w, input string tag);
    logic [31:0] r;
    logic bsy, dn, ng, er;
    sample(w, r, bsy, dn, ng, er);
    check({tag, "_res"},  r, 0);
    check({tag, "_busy"}, 32'(bsy), 0);
    check({tag, "_done"}, 32'(dn), 0);
    check({tag, "_neg"},  32'(ng), 0);
    check({tag, "_err"},  32'(er), 0);
  endtask

  // Called away from the clock edge; returns #1 after done edge.
  task automatic run_op(
    input int w, input logic [1:0] o,
    input int x, input int y, input bit noise
  );
    int mask, ex_res, ex_lat, n;
    bit ex_neg, ex_err;
    logic [31:0] r;
    logic bsy, dn, ng, er;
    mask = (1 << w) - 1;
    x = x & mask;
    y = y & mask;
    ex_neg = 0; ex_err = 0; ex_lat = 1;
    case (o)
      2'b00: ex_res = x + y;
      2'b01: begin
        ex_neg = x < y;
        ex_res = ex_neg ? y - x : x - y;
      end
      2'b10: begin
        ex_res = x * y;
        ex_lat = w + 1;
      end
      default: begin
        if (y == 0) begin
          ex_res = (1 << (2 * w)) - 1;
          ex_err = 1;
        end else begin
          ex_res = ((x % y) << w) | (x / y);
          ex_lat = w + 1;
        end
      end
    endcase
    drive(w, 1'b1, o, x, y);
    @(posedge clk); #1;
    sample(w, r, bsy, dn, ng, er);
    check("busy_acc", 32'(bsy), 1);
    check("neg_clr", 32'(ng), 0);
    check("err_clr", 32'(er), 0);
    n = 0;
    do begin
      drive(w, noise ? 1'($urandom % 2) : 1'b0,
            2'($urandom), int'($urandom), int'($urandom));
      @(posedge clk); #1;
      n++;
      sample(w, r, bsy, dn, ng, er);
      if (!dn && n < ex_lat) check("busy_hold", 32'(bsy), 1);
    end while (!dn && n < 40);
    drive(w, 1'b0, 2'b00, 0, 0);
    check("latency", n, ex_lat);
    check("done", 32'(dn), 1);
    check("busy_end", 32'(bsy), 0);
    check("result", r, 32'(ex_res));
    check("neg", 32'(ng), 32'(ex_neg));
    check("err", 32'(er), 32'(ex_err));
  endtask

  task automatic idle_chk(input int w, input int exp_res);
    logic [31:0] r;
    logic bsy, dn, ng, er;
    drive(w, 1'b0, 2'b00, 0, 0);
    @(posedge clk); #1;
    sample(w, r, bsy, dn, ng, er);
    check("done_pulse", 32'(dn), 0);
    check("idle_busy", 32'(bsy), 0);
    check("res_hold", r, 32'(exp_res));
  endtask

  initial begin
    int w;
    logic [31:0] r;
    logic bsy, dn, ng, er;
    drive(3, 1'b0, 2'b00, 0, 0);
    drive(8, 1'b0, 2'b00, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk_zero(3, "rst3");
    chk_zero(8, "rst8");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(3, 2'b00, 5, 6, 0);
    idle_chk(3, 11);
    run_op(3, 2'b01, 2, 5, 0);
    run_op(3, 2'b01, 5, 2, 0);
    run_op(3, 2'b10, 7, 7, 0);
    run_op(3, 2'b10, 0, 7, 0);
    run_op(3, 2'b11, 7, 2, 0);
    run_op(3, 2'b11, 5, 0, 0);
    idle_chk(3, 63);

    // Extra start pulses while busy must not be serviced.
    drive(3, 1'b1, 2'b10, 6, 5);
    @(posedge clk); #1;
    for (int c = 1; c <= 6; c++) begin
      drive(3, (c == 1 || c == 3), 2'b00, 1, 1);
      @(posedge clk); #1;
      sample(3, r, bsy, dn, ng, er);
      if (c == 4) check("mul_noise_done", r, 30);
      check("mul_noise_pulse", 32'(dn), 32'(c == 4));
    end

    // Reset in the middle of a divide.
    @(negedge clk);
    drive(3, 1'b1, 2'b11, 7, 2);
    @(posedge clk); #1;
    drive(3, 1'b0, 2'b00, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_zero(3, "mid_rst");
    repeat (2) begin
      @(posedge clk); #1;
      sample(3, r, bsy, dn, ng, er);
      check("rst_no_done", 32'(dn), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(3, 2'b00, 3, 4, 0);

    run_op(8, 2'b10, 255, 255, 0);
    run_op(8, 2'b11, 200, 7, 0);
    run_op(8, 2'b11, 9, 0, 0);
    idle_chk(8, 65535);

    // Back-to-back random traffic with start noise while busy.
    for (int i = 0; i < 60; i++) begin
      w = ($urandom % 2) ? 8 : 3;
      run_op(w, 2'($urandom), int'($urandom),
             ($urandom % 5 == 0) ? 0 : int'($urandom),
             1'($urandom % 2));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
